// File: rtl/axis_pkg.sv
// Shared types for the two-source AXI-Stream merger.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  localparam logic SRC_IN1 = 1'b0;
  localparam logic SRC_IN2 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin tie-break; gnt_o[0] = in1, gnt_o[1] = in2.
module rr_arbiter2
  import axis_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == SRC_IN2) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/axis_merger.sv
// Merges two AXI-Stream sources into one registered output stream.
// Define AXIS_MERGER_PACKET_LOCK_EN to hold a grant until tlast.
module axis_merger
  import axis_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              axis_aclk,
  input  logic              axis_areset,
  input  logic              in1_axis_tvalid,
  output logic              in1_axis_tready,
  input  logic [DATA_W-1:0] in1_axis_tdata,
  input  logic              in1_axis_tlast,
  input  logic              in2_axis_tvalid,
  output logic              in2_axis_tready,
  input  logic [DATA_W-1:0] in2_axis_tdata,
  input  logic              in2_axis_tlast,
  output logic              out_axis_tvalid,
  input  logic              out_axis_tready,
  output logic [DATA_W-1:0] out_axis_tdata,
  output logic              out_axis_tlast,
  output logic              out_axis_tuser
);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tlast_q, tlast_d;
  logic                user_q, user_d;
  logic [1:0]          gnt;
  logic                room;
  logic                acc1, acc2, acc;
  logic                end_grant;

  rr_arbiter2 u_arb (
    .req_i  ({in2_axis_tvalid, in1_axis_tvalid}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Output register can take a beat if empty or draining this cycle
  assign room = !vld_q || out_axis_tready;

  assign in1_axis_tready = (state_q == GRANT1) && room;
  assign in2_axis_tready = (state_q == GRANT2) && room;

  assign acc1 = in1_axis_tvalid && in1_axis_tready;
  assign acc2 = in2_axis_tvalid && in2_axis_tready;
  assign acc  = acc1 || acc2;

`ifdef AXIS_MERGER_PACKET_LOCK_EN
  logic acc_last;
  assign acc_last  = acc1 ? in1_axis_tlast : in2_axis_tlast;
  assign end_grant = acc && acc_last;
`else
  assign end_grant = acc;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          state_d = GRANT1;
          last_d  = SRC_IN1;
        end else if (gnt[1]) begin
          state_d = GRANT2;
          last_d  = SRC_IN2;
        end
      end
      GRANT1,
      GRANT2: begin
        if (end_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    tlast_d = tlast_q;
    user_d  = user_q;
    if (acc) begin
      vld_d   = 1'b1;
      data_d  = acc2 ? in2_axis_tdata : in1_axis_tdata;
      tlast_d = acc2 ? in2_axis_tlast : in1_axis_tlast;
      user_d  = acc2 ? SRC_IN2 : SRC_IN1;
    end else if (vld_q && out_axis_tready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q <= IDLE;
      last_q  <= SRC_IN2;
      vld_q   <= 1'b0;
      data_q  <= '0;
      tlast_q <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      tlast_q <= tlast_d;
      user_q  <= user_d;
    end
  end

  assign out_axis_tvalid = vld_q;
  assign out_axis_tdata  = data_q;
  assign out_axis_tlast  = tlast_q;
  assign out_axis_tuser  = user_q;

endmodule

// File: tb/tb_axis_merger.sv
// Directed self-checking bench for axis_merger (both lock modes).
module tb_axis_merger;

  localparam int DW = 32;
`ifdef AXIS_MERGER_PACKET_LOCK_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in1_tvalid = 1'b0, in1_tready, in1_tlast = 1'b0;
  logic [DW-1:0] in1_tdata = '0;
  logic          in2_tvalid = 1'b0, in2_tready, in2_tlast = 1'b0;
  logic [DW-1:0] in2_tdata = '0;
  logic          out_tvalid, out_tready = 1'b1, out_tlast, out_tuser;
  logic [DW-1:0] out_tdata;

  axis_merger #(.DATA_W(DW)) dut (
    .axis_aclk       (clk),
    .axis_areset     (rst),
    .in1_axis_tvalid (in1_tvalid),
    .in1_axis_tready (in1_tready),
    .in1_axis_tdata  (in1_tdata),
    .in1_axis_tlast  (in1_tlast),
    .in2_axis_tvalid (in2_tvalid),
    .in2_axis_tready (in2_tready),
    .in2_axis_tdata  (in2_tdata),
    .in2_axis_tlast  (in2_tlast),
    .out_axis_tvalid (out_tvalid),
    .out_axis_tready (out_tready),
    .out_axis_tdata  (out_tdata),
    .out_axis_tlast  (out_tlast),
    .out_axis_tuser  (out_tuser)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW:0]   q1[$];
  logic [DW:0]   q2[$];
  bit            en1 = 1'b1, en2 = 1'b1;
  bit            hs1 = 1'b0, hs2 = 1'b0;
  logic [DW+1:0] cap_d[$];
  int            cap_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    hs1 = in1_tvalid && in1_tready;
    hs2 = in2_tvalid && in2_tready;
    if (!rst && out_tvalid && out_tready) begin
      cap_d.push_back({out_tuser, out_tlast, out_tdata});
      cap_c.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst && hs1 && q1.size() > 0) void'(q1.pop_front());
    if (!rst && hs2 && q2.size() > 0) void'(q2.pop_front());
    in1_tvalid = en1 && (q1.size() > 0);
    {in1_tlast, in1_tdata} = (q1.size() > 0) ? q1[0] : '0;
    in2_tvalid = en2 && (q2.size() > 0);
    {in2_tlast, in2_tdata} = (q2.size() > 0) ? q2[0] : '0;
  end

  function automatic logic [DW+1:0] mk(input logic u, input logic l,
                                       input logic [DW-1:0] d);
    return {u, l, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cap(input int n, input string tag);
    int k = 0;
    while (cap_d.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(cap_d.size() >= n), 64'd1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_vld"}, 64'(out_tvalid), 64'd0);
    chk({tag, "_rdy1"}, 64'(in1_tready), 64'd0);
    chk({tag, "_rdy2"}, 64'(in2_tready), 64'd0);
    chk({tag, "_last"}, 64'(out_tlast), 64'd0);
    chk({tag, "_user"}, 64'(out_tuser), 64'd0);
    chk({tag, "_data"}, 64'(out_tdata), 64'd0);
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_c.delete();
  endtask

  initial begin
    int rel;
    int n;
    logic [DW+1:0] exp[$];
    logic [DW+1:0] s0[$];
    logic [DW+1:0] s1[$];

    // single source, 4-beat packet
    for (int i = 0; i < 4; i++) q1.push_back({i == 3, 32'(32'h11 + i)});
    @(negedge clk);
    chk_rst("rst0");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rel = cyc;
    rst = 1'b0;
    wait_cap(4, "t1_cnt");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_beat%0d", i), 64'(cap_d[i]),
          64'(mk(1'b0, i == 3, 32'(32'h11 + i))));
    chk("t1_lat", 64'(cap_c[0]), 64'(rel + 2));
    for (int i = 0; i < 3; i++)
      chk($sformatf("t1_gap%0d", i), 64'(cap_c[i+1] - cap_c[i]), 64'(GAP));
    clear_cap();

    // both sources valid from reset
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q1.push_back({i == 2, 32'(32'hA0 + i)});
      q2.push_back({i == 2, 32'(32'hB0 + i)});
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp.delete();
`ifdef AXIS_MERGER_PACKET_LOCK_EN
    for (int i = 0; i < 3; i++) exp.push_back(mk(1'b0, i == 2, 32'(32'hA0 + i)));
    for (int i = 0; i < 3; i++) exp.push_back(mk(1'b1, i == 2, 32'(32'hB0 + i)));
`else
    for (int i = 0; i < 3; i++) begin
      exp.push_back(mk(1'b0, i == 2, 32'(32'hA0 + i)));
      exp.push_back(mk(1'b1, i == 2, 32'(32'hB0 + i)));
    end
`endif
    wait_cap(6, "t2_cnt");
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_beat%0d", i), 64'(cap_d[i]), 64'(exp[i]));
    clear_cap();

    // output backpressure with 0xDEAD pending
    @(posedge clk);
    #1 out_tready = 1'b0;
    @(negedge clk);
    q1.push_back({1'b0, 32'hDEAD});
    q1.push_back({1'b1, 32'hBEEF});
    n = 0;
    while (!out_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_vld", 64'(out_tvalid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold%0d", i), 64'(out_tdata), 64'hDEAD);
      chk($sformatf("t3_rdy%0d", i), 64'(in1_tready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_tready = 1'b1;
    wait_cap(2, "t3_cnt");
    chk("t3_b0", 64'(cap_d[0]), 64'(mk(1'b0, 1'b0, 32'hDEAD)));
    chk("t3_b1", 64'(cap_d[1]), 64'(mk(1'b0, 1'b1, 32'hBEEF)));
    clear_cap();

    // in2 stalls mid-packet while in1 waits
    @(negedge clk);
    for (int i = 0; i < 4; i++) q2.push_back({i == 3, 32'(32'hC0 + i)});
    q1.push_back({1'b1, 32'hD0});
    n = 0;
    while (q2.size() > 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    en2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifdef AXIS_MERGER_PACKET_LOCK_EN
      chk($sformatf("t4_blk%0d", i), 64'(in1_tready), 64'd0);
`endif
    end
    en2 = 1'b1;
    wait_cap(5, "t4_cnt");
    foreach (cap_d[i]) begin
      if (cap_d[i][DW+1]) s1.push_back(cap_d[i]);
      else s0.push_back(cap_d[i]);
    end
    chk("t4_n0", 64'(s0.size()), 64'd1);
    chk("t4_n1", 64'(s1.size()), 64'd4);
    chk("t4_d0", 64'(s0[0]), 64'(mk(1'b0, 1'b1, 32'hD0)));
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_c%0d", i), 64'(s1[i]),
          64'(mk(1'b1, i == 3, 32'(32'hC0 + i))));
`ifdef AXIS_MERGER_PACKET_LOCK_EN
    chk("t4_order", 64'(cap_d[4]), 64'(mk(1'b0, 1'b1, 32'hD0)));
`endif
    clear_cap();

    // reset pulse mid-packet
    @(negedge clk);
    for (int i = 0; i < 4; i++) q1.push_back({i == 3, 32'(32'hE0 + i)});
    wait_cap(2, "t5_pre");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_rst("rst1");
    q1.delete();
    q2.delete();
    clear_cap();
    q1.push_back({1'b1, 32'hF0});
    q2.push_back({1'b1, 32'h60});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rel = cyc;
    rst = 1'b0;
    wait_cap(2, "t5_cnt");
    chk("t5_first", 64'(cap_d[0]), 64'(mk(1'b0, 1'b1, 32'hF0)));
    chk("t5_lat", 64'(cap_c[0]), 64'(rel + 2));
    chk("t5_second", 64'(cap_d[1]), 64'(mk(1'b1, 1'b1, 32'h60)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
